// File: rtl/sync_fifo_pkg.sv
// Shared constants and width helpers for the sync_fifo family.
package sync_fifo_pkg;

    localparam ARCH_XILINX  = "Xilinx";
    localparam ARCH_GENERIC = "Generic";

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// ARCH selects block-RAM inference attributes ("Xilinx") or plain inference ("Generic").
module sdp_ram
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = 19,
    parameter int DEPTH = 128,
    parameter     ARCH  = ARCH_XILINX,
    parameter int AW    = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    generate
        if (ARCH == ARCH_XILINX) begin : g_bram
            (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

            always_ff @(posedge clk) begin
                if (wr_en) begin
                    mem[wr_addr] <= wr_data;
                end
                rd_data <= mem[rd_addr];
            end
        end else begin : g_generic
            logic [WIDTH-1:0] mem [DEPTH];

            always_ff @(posedge clk) begin
                if (wr_en) begin
                    mem[wr_addr] <= wr_data;
                end
                rd_data <= mem[rd_addr];
            end
        end
    endgenerate

endmodule

// File: rtl/sync_fifo_ext.sv
// First-word-fall-through FIFO of any depth with fill level, almost flags and flush; 1-cycle push-to-visible.
// Optional high-watermark ports i_peak_clr/o_peak are built when SYNC_FIFO_EXT_PEAK_EN is defined.
module sync_fifo_ext
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH         = 19,
    parameter int DEPTH         = 128,
    parameter int AFULL_THRESH  = DEPTH - 4,
    parameter int AEMPTY_THRESH = 4,
    parameter     ARCH          = ARCH_XILINX,
    parameter int CW            = cnt_w(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_wr_en,
    output logic             o_full,
    output logic             o_wr_err,
    input  logic             i_rd_incr,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_rd_err,
    output logic [CW-1:0]    o_count,
`ifdef SYNC_FIFO_EXT_PEAK_EN
    input  logic             i_peak_clr,
    output logic [CW-1:0]    o_peak,
`endif
    output logic             o_afull,
    output logic             o_aempty
);

    localparam int PW = ptr_w(DEPTH);
    localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [CW-1:0]    count, count_n;
    logic             push, pop, ram_we, head_from_ram, load_head;
    logic             wr_err_n, rd_err_n, fwd_vld;
    logic [WIDTH-1:0] ram_q, fwd_dat, head_dat;

    // o_data is the head word; the RAM holds the remaining count-1 words starting at rd_ptr.
    always_comb begin
        push          = i_wr_en && !o_full;
        pop           = i_rd_incr && !o_empty;
        head_from_ram = pop && (count >= CW'(2));
        ram_we        = push && !o_empty && !(pop && count == CW'(1)) && !i_flush;
        wr_err_n      = i_wr_en && o_full && !i_flush;
        rd_err_n      = i_rd_incr && o_empty && !i_flush;
        count_n       = count + CW'(push) - CW'(pop);
        wr_ptr_n      = ram_we ? ptr_inc(wr_ptr) : wr_ptr;
        rd_ptr_n      = head_from_ram ? ptr_inc(rd_ptr) : rd_ptr;
        load_head     = 1'b0;
        head_dat      = i_data;
        if (!i_flush) begin
            if (head_from_ram) begin
                load_head = 1'b1;
                head_dat  = fwd_vld ? fwd_dat : ram_q;
            end else if (push && (o_empty || pop)) begin
                load_head = 1'b1;
            end
        end
        if (i_rst || i_flush) begin
            count_n  = '0;
            wr_ptr_n = '0;
            rd_ptr_n = '0;
        end
    end

    // The RAM read is issued at rd_ptr_n so its output already holds the next head; a write landing on
    // that same address is forwarded for one cycle to cover the read-during-write case.
    sdp_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ARCH  (ARCH),
        .AW    (PW)
    ) u_ram (
        .clk     (i_clk),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr),
        .wr_data (i_data),
        .rd_addr (rd_ptr_n),
        .rd_data (ram_q)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            o_empty  <= 1'b1;
            o_aempty <= 1'b1;
            o_full   <= 1'b0;
            o_afull  <= 1'b0;
            o_wr_err <= 1'b0;
            o_rd_err <= 1'b0;
            o_data   <= '0;
            fwd_vld  <= 1'b0;
        end else begin
            count    <= count_n;
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            o_empty  <= (count_n == '0);
            o_aempty <= (count_n <= AEMPTY_C);
            o_full   <= (count_n == FULL_C);
            o_afull  <= (count_n >= AFULL_C);
            o_wr_err <= wr_err_n;
            o_rd_err <= rd_err_n;
            fwd_vld  <= ram_we && (wr_ptr == rd_ptr_n);
            if (load_head) begin
                o_data <= head_dat;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        fwd_dat <= i_data;
    end

    assign o_count = count;

`ifdef SYNC_FIFO_EXT_PEAK_EN
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            o_peak <= '0;
        end else if (i_peak_clr) begin
            o_peak <= count_n;
        end else if (count_n > o_peak) begin
            o_peak <= count_n;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Bench for sync_fifo_ext: vector table, directed fill/drain/flush on DEPTH=128, random run against a queue model on DEPTH=5.
module tb_sync_fifo_ext;
    import sync_fifo_pkg::*;

    localparam int DA  = 128;
    localparam int CWA = cnt_w(DA);
    localparam int DB  = 5;
    localparam int CWB = cnt_w(DB);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nbad = 0;

    logic            a_rst, a_flush, a_wr, a_rd;
    logic [18:0]     a_din, a_dout;
    logic            a_full, a_empty, a_werr, a_rerr, a_afull, a_aempty;
    logic [CWA-1:0]  a_count;
    logic            b_rst, b_flush, b_wr, b_rd;
    logic [7:0]      b_din, b_dout;
    logic            b_full, b_empty, b_werr, b_rerr, b_afull, b_aempty;
    logic [CWB-1:0]  b_count;
`ifdef SYNC_FIFO_EXT_PEAK_EN
    logic            a_peak_clr, b_peak_clr;
    logic [CWA-1:0]  a_peak;
    logic [CWB-1:0]  b_peak;
`endif

    sync_fifo_ext #(.WIDTH(19), .DEPTH(DA)) dut_a (
        .i_clk(clk), .i_rst(a_rst), .i_flush(a_flush), .i_data(a_din), .i_wr_en(a_wr),
        .o_full(a_full), .o_wr_err(a_werr), .i_rd_incr(a_rd), .o_data(a_dout),
        .o_empty(a_empty), .o_rd_err(a_rerr), .o_count(a_count),
`ifdef SYNC_FIFO_EXT_PEAK_EN
        .i_peak_clr(a_peak_clr), .o_peak(a_peak),
`endif
        .o_afull(a_afull), .o_aempty(a_aempty)
    );

    sync_fifo_ext #(.WIDTH(8), .DEPTH(DB), .AFULL_THRESH(DB - 4), .AEMPTY_THRESH(4)) dut_b (
        .i_clk(clk), .i_rst(b_rst), .i_flush(b_flush), .i_data(b_din), .i_wr_en(b_wr),
        .o_full(b_full), .o_wr_err(b_werr), .i_rd_incr(b_rd), .o_data(b_dout),
        .o_empty(b_empty), .o_rd_err(b_rerr), .o_count(b_count),
`ifdef SYNC_FIFO_EXT_PEAK_EN
        .i_peak_clr(b_peak_clr), .o_peak(b_peak),
`endif
        .o_afull(b_afull), .o_aempty(b_aempty)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ctl = {rst, flush, wr, rd}; flg = {empty, full, afull, aempty, wr_err, rd_err}
    typedef struct {
        logic [3:0]  ctl;
        logic [18:0] din;
        logic [7:0]  e_cnt;
        logic [5:0]  e_flg;
        logic        chk_dat;
        logic [18:0] e_dat;
    } vec_t;

    vec_t tbl [11];

    logic [7:0] q [$];
    int         m_peak;

    initial begin
        tbl[0]  = '{4'b1000, 19'h000, 8'd0, 6'b100100, 1'b1, 19'h000};
        tbl[1]  = '{4'b0011, 19'h05A, 8'd1, 6'b000101, 1'b1, 19'h05A};
        tbl[2]  = '{4'b0000, 19'h000, 8'd1, 6'b000100, 1'b1, 19'h05A};
        tbl[3]  = '{4'b0010, 19'h011, 8'd2, 6'b000100, 1'b1, 19'h05A};
        tbl[4]  = '{4'b0011, 19'h022, 8'd2, 6'b000100, 1'b1, 19'h011};
        tbl[5]  = '{4'b0001, 19'h000, 8'd1, 6'b000100, 1'b1, 19'h022};
        tbl[6]  = '{4'b0001, 19'h000, 8'd0, 6'b100100, 1'b0, 19'h000};
        tbl[7]  = '{4'b0001, 19'h000, 8'd0, 6'b100101, 1'b0, 19'h000};
        tbl[8]  = '{4'b0110, 19'h033, 8'd0, 6'b100100, 1'b1, 19'h022};
        tbl[9]  = '{4'b0010, 19'h044, 8'd1, 6'b000100, 1'b1, 19'h044};
        tbl[10] = '{4'b1010, 19'h055, 8'd0, 6'b100100, 1'b1, 19'h000};

        {a_rst, a_flush, a_wr, a_rd} = 4'b0000;
        {b_rst, b_flush, b_wr, b_rd} = 4'b1000;
        a_din = '0;
        b_din = '0;
`ifdef SYNC_FIFO_EXT_PEAK_EN
        a_peak_clr = 1'b0;
        b_peak_clr = 1'b0;
`endif
        tick();

        for (int i = 0; i < 11; i++) begin
            {a_rst, a_flush, a_wr, a_rd} = tbl[i].ctl;
            a_din = tbl[i].din;
            tick();
            chk($sformatf("tbl%0d_count", i), 32'(a_count), 32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_flags", i),
                32'({a_empty, a_full, a_afull, a_aempty, a_werr, a_rerr}), 32'(tbl[i].e_flg));
            if (tbl[i].chk_dat)
                chk($sformatf("tbl%0d_data", i), 32'(a_dout), 32'(tbl[i].e_dat));
        end
        {a_rst, a_flush, a_wr, a_rd} = 4'b0000;

        // Fill to capacity, then one push too many.
        a_wr = 1'b1;
        for (int i = 0; i < DA; i++) begin
            a_din = 19'(i);
            tick();
            chk("fill_count", 32'(a_count), 32'(i + 1));
            chk("fill_afull", 32'(a_afull), 32'((i + 1) >= DA - 4));
            chk("fill_full", 32'(a_full), 32'((i + 1) == DA));
        end
        a_din = 19'h7FFFF;
        tick();
        chk("ovf_wr_err", 32'(a_werr), 32'd1);
        chk("ovf_count", 32'(a_count), 32'(DA));
        a_wr = 1'b0;
        tick();
        chk("ovf_wr_err_clear", 32'(a_werr), 32'd0);

        // Back-to-back drain: a new head must appear every cycle.
        a_rd = 1'b1;
        for (int i = 0; i < DA; i++) begin
            chk("drain_data", 32'(a_dout), 32'(i));
            chk("drain_empty", 32'(a_empty), 32'd0);
            tick();
        end
        a_rd = 1'b0;
        chk("drain_end_empty", 32'(a_empty), 32'd1);
        chk("drain_end_count", 32'(a_count), 32'd0);
        chk("drain_end_rd_err", 32'(a_rerr), 32'd0);

        // Flush with concurrent push and pop at count 10.
        a_wr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a_din = 19'(100 + i);
            tick();
        end
        chk("preflush_count", 32'(a_count), 32'd10);
        {a_flush, a_wr, a_rd} = 3'b111;
        tick();
        {a_flush, a_wr, a_rd} = 3'b000;
        chk("flush_count", 32'(a_count), 32'd0);
        chk("flush_flags", 32'({a_empty, a_full, a_afull, a_aempty, a_werr, a_rerr}), 32'b100100);

`ifdef SYNC_FIFO_EXT_PEAK_EN
        a_wr = 1'b1;
        for (int i = 0; i < 7; i++) begin
            a_din = 19'(i);
            tick();
        end
        a_wr = 1'b0;
        a_rd = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        a_rd = 1'b0;
        chk("peak_hold", 32'(a_peak), 32'd7);
        a_peak_clr = 1'b1;
        tick();
        a_peak_clr = 1'b0;
        chk("peak_clr", 32'(a_peak), 32'd4);
`endif

        // Random traffic on the DEPTH=5 instance against a queue model.
        b_rst = 1'b0;
        m_peak = 0;
        for (int c = 0; c < 800; c++) begin
            bit         w, r, f, e_werr, e_rerr;
            logic [7:0] d;
            w = ($urandom_range(0, 99) < ((c % 100) < 50 ? 75 : 30));
            r = ($urandom_range(0, 99) < 55);
            f = ($urandom_range(0, 29) == 0);
            d = 8'($urandom);
            {b_flush, b_wr, b_rd} = {f, w, r};
            b_din = d;
            e_werr = w && (q.size() == DB) && !f;
            e_rerr = r && (q.size() == 0) && !f;
            if (f) begin
                q.delete();
                m_peak = 0;
            end else begin
                bit do_pop, do_push;
                do_pop  = r && (q.size() > 0);
                do_push = w && (q.size() < DB);
                if (do_pop) void'(q.pop_front());
                if (do_push) q.push_back(d);
                if (q.size() > m_peak) m_peak = q.size();
            end
            tick();
            chk("rnd_count", 32'(b_count), 32'(q.size()));
            chk("rnd_flags", 32'({b_empty, b_full, b_afull, b_aempty, b_werr, b_rerr}),
                32'({q.size() == 0, q.size() == DB, q.size() >= DB - 4, q.size() <= 4, e_werr, e_rerr}));
            if (q.size() > 0)
                chk("rnd_data", 32'(b_dout), 32'(q[0]));
`ifdef SYNC_FIFO_EXT_PEAK_EN
            chk("rnd_peak", 32'(b_peak), 32'(m_peak));
`endif
        end
        {b_flush, b_wr, b_rd} = 3'b000;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ext.md
# sync_fifo_ext

Parametrised synchronous first-word-fall-through FIFO and next generation of `sync_fifo`. It supports arbitrary (non-power-of-2) depth, exposes the fill level, and provides programmable almost-full/almost-empty flags and a synchronous flush. It is the standard single-clock buffer between streaming producers and consumers in the datapath. The port names and error semantics of `sync_fifo` carry over unchanged, so existing instances can migrate.

## Interface
- `WIDTH`, 19: data width in bits, ≥1
- `DEPTH`, 128: capacity in words, ≥2, any integer
- `AFULL_THRESH`, DEPTH-4: `o_afull` asserts when count ≥ this value; range 1..DEPTH
- `AEMPTY_THRESH`, 4: `o_aempty` asserts when count ≤ this value; range 0..DEPTH-1
- `ARCH`, "Xilinx": storage inference style, either "Xilinx" (block-RAM attributes) or "Generic"

Ports:
- `i_clk` in 1: clock, all logic is rising-edge
- `i_rst` in 1: reset, synchronous, active-high
- `i_flush` in 1: synchronous clear of contents
- `i_data` in WIDTH: write data
- `i_wr_en` in 1: push request
- `o_full` out 1: count == DEPTH
- `o_wr_err` out 1: one-cycle pulse, push dropped
- `i_rd_incr` in 1: pop the head word
- `o_data` out WIDTH: head word, valid while `!o_empty`
- `o_empty` out 1: count == 0
- `o_rd_err` out 1: one-cycle pulse, pop ignored
- `o_count` out CW: current fill, CW = $clog2(DEPTH+1)
- `o_afull` out 1: almost full
- `o_aempty` out 1: almost empty

## Operation
- **Reset values:** count 0, `o_empty`=1, `o_aempty`=1, `o_full`=0, `o_afull`=0, `o_wr_err`=0, `o_rd_err`=0, `o_data`=0, pointers 0. RAM contents are not cleared.
- **Write acceptance:** a push is accepted when `i_wr_en` && !`o_full`. If `i_wr_en` && `o_full`, the word is dropped and `o_wr_err` pulses next cycle. This holds even if `i_rd_incr` is asserted in the same cycle; there is no full-bypass.
- **Read acceptance:** a pop is accepted when `i_rd_incr` && !`o_empty`. If `i_rd_incr` && `o_empty`, `o_rd_err` pulses next cycle, even if `i_wr_en` is asserted in the same cycle.
- **Simultaneous push and pop** when 0<count<DEPTH: both are accepted and count is unchanged.
- **Pointers:** write and read pointers wrap from DEPTH-1 to 0 with an explicit compare, not power-of-2 masking.
- **Output stage:** FWFT with a one-word output register counted in `o_count`. A push into an empty FIFO bypasses RAM into the output register.
- **Flags:** all flags are registered and derived from the next-count value.
- **Flush:** `i_flush` has priority over push and pop. Next cycle the state equals post-reset state (`o_data` holds its last value). No error pulses are generated in the flush cycle.
- **Reset mid-operation:** any cycle with `i_rst` high forces reset values on the next edge, regardless of the other inputs.

## Timing
- **Push to visible:** a push at edge N into an empty FIFO gives `o_empty`=0 and valid `o_data` after edge N. This is a 1-cycle latency.
- **Pop:** a pop at edge N presents the next word on `o_data` after edge N. RAM prefetch is arranged so back-to-back pops sustain 1 word/cycle with no bubbles.
- **Flags and count** update on the same edge as the accepted operation.
- **Error pulses** are high for exactly the one cycle after the offending edge.
- **Throughput:** 1 push and 1 pop per cycle, sustained.

## Configuration
- **`SYNC_FIFO_EXT_PEAK_EN` defined:** adds two ports.
  - `i_peak_clr` (in 1) clears the peak.
  - `o_peak` (out CW) is a registered high-watermark of `o_count` since the last reset, flush, or `i_peak_clr`.
  - `i_peak_clr` in the same cycle as a push loads the new count.
- **Undefined:** both ports and the peak logic are absent. All other behaviour is identical.

## Structure
- **Package `sync_fifo_pkg`:**
  - arch name constants "Xilinx"/"Generic"
  - function `cnt_w(depth)` returning $clog2(depth+1)
  - function `ptr_w(depth)` returning max(1,$clog2(depth))
- **Sub-module `sdp_ram`:** simple dual-port RAM with synchronous read, parameters WIDTH/DEPTH/ARCH, carrying the ARCH-dependent RAM style attributes.

## Test plan
- **Reset:** after reset → `o_empty`=1, `o_aempty`=1, `o_count`=0, `o_full`=0, no error pulses.
- **Fill and drain (DEPTH=128):** push 0..127 → `o_full`=1, `o_count`=128, `o_afull` from count 124. A 129th push → `o_wr_err`=1 for one cycle and count stays 128. Pop 128 times → data 0..127 in order with no bubbles.
- **Non-power-of-2 wrap (DEPTH=5):** 12 interleaved push/pop cycles → pointer wrap 4→0 and data order preserved.
- **Read on empty with push:** empty FIFO, `i_wr_en`=1 and `i_rd_incr`=1 with data 0x5A → `o_rd_err` pulses, then `o_count`=1 and `o_data`=0x5A.
- **Flush with push and pop:** count 10, `i_flush` with push and pop → count 0, `o_empty`=1, no error pulses.
- **Peak (`SYNC_FIFO_EXT_PEAK_EN`):** push 7, pop 3 → `o_peak`=7. Pulse `i_peak_clr` → `o_peak`=4.
